// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave keypad entry path.
package microwave_pkg;

    localparam int NUM_DIGITS_DEF   = 4;
    localparam int SEC_TENS_MAX_DEF = 5;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    function automatic logic is_bcd(input digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Rising-edge detector for the keypad encoder strobe.
module key_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    // History clears in reset, so a key held through release still fires once.
    assign rise = level & ~prev;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad digit entry FSM and MM:SS buffer feeding the countdown timer.
module keypad_entry_ctrl
    import microwave_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd,
    input  logic       loadn,
    input  logic       clear,
    input  logic       start,
    input  logic       time_ack,
    input  logic       timer_busy,
    output logic       enable,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] digit_count,
    output logic       time_load,
    output logic       entry_err,
    output logic       abort
);

    state_t         state;
    digit_t [3:0]   digits;
    logic           key_evt;
    logic           key_ok;
    logic           full;
    logic           time_ok;

    key_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .level (loadn),
        .rise  (key_evt)
    );

    assign key_ok  = key_evt && is_bcd(bcd);
    assign full    = digit_count >= 3'(NUM_DIGITS);
    assign time_ok = (|digits) && (digits[1] <= 4'(SEC_TENS_MAX));

    assign min_tens = digits[3];
    assign min_ones = digits[2];
    assign sec_tens = digits[1];
    assign sec_ones = digits[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            digits      <= '0;
            digit_count <= '0;
            time_load   <= 1'b0;
            entry_err   <= 1'b0;
            abort       <= 1'b0;
            enable      <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            abort     <= 1'b0;
            case (state)
                // clear/start outrank a key here even though both are no-ops
                S_IDLE: begin
                    if (!clear && !start && key_ok && !full) begin
                        digits      <= {digits[2:0], bcd};
                        digit_count <= digit_count + 3'd1;
                        state       <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (clear) begin
                        digits      <= '0;
                        digit_count <= '0;
                        state       <= S_IDLE;
                    end else if (start) begin
                        if (time_ok) begin
                            state     <= S_LOAD;
                            time_load <= 1'b1;
                            enable    <= 1'b1;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end else if (key_ok && !full) begin
                        digits      <= {digits[2:0], bcd};
                        digit_count <= digit_count + 3'd1;
                    end
                end
                S_LOAD: begin
                    if (time_ack) begin
                        state     <= S_RUN;
                        time_load <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (clear || !timer_busy) begin
                        abort       <= clear;
                        digits      <= '0;
                        digit_count <= '0;
                        enable      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
